// File: rtl/load_sequencer_pkg.sv
// load_sequencer_pkg: state encodings and width helper shared by the load sequencer files
package load_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_sequencer_if.sv
// load_sequencer_if: control inputs and register-bank strobes between controller and datapath
interface load_sequencer_if #(
    parameter int CHANNELS     = 4,
    parameter int LOADS_PER_CH = 8
);
    import load_sequencer_pkg::*;

    localparam int CH_W  = clog2w(CHANNELS);
    localparam int CNT_W = clog2w(LOADS_PER_CH);

    logic                start;
    logic                pause;
    logic                abort;
    logic                clear;
    logic [CHANNELS-1:0] load;
    logic [CH_W-1:0]     channel_idx;
    logic [CNT_W-1:0]    load_count;
    logic                busy;
    logic                done;

    modport master (
        output start, pause, abort,
        input  clear, load, channel_idx, load_count, busy, done
    );

    modport slave (
        input  start, pause, abort,
        output clear, load, channel_idx, load_count, busy, done
    );

endinterface

// File: rtl/load_sequencer_onehot_decoder.sv
// onehot_decoder: turns a channel index plus enable into a one-hot load vector
module onehot_decoder
    import load_sequencer_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int CH_W     = clog2w(CHANNELS)
) (
    input  logic [CH_W-1:0]     idx,
    input  logic                en,
    output logic [CHANNELS-1:0] onehot
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_bit
        assign onehot[i] = en && (idx == CH_W'(i));
    end

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: clear phase, then round-robin one-hot load strobes with pause/abort and a done pulse
module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int LOADS_PER_CH = 8
) (
    input  logic          clock,
    input  logic          reset,
    load_sequencer_if.slave bus
);

    localparam int CH_W  = clog2w(CHANNELS);
    localparam int CNT_W = clog2w(LOADS_PER_CH);
    localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOADS_PER_CH - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = idx_q == IDX_LAST;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                state_d = bus.start ? ST_LOAD : ST_CLEAR;
                idx_d   = '0;
                cnt_d   = '0;
            end
            ST_LOAD: begin
                // abort outranks both pause and completion
                if (bus.abort) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (!bus.pause) begin
                    idx_d   = wrap ? '0 : idx_q + CH_W'(1);
                    cnt_d   = (wrap && cnt_q != CNT_LAST) ? cnt_q + CNT_W'(1) : cnt_q;
                    state_d = (wrap && cnt_q == CNT_LAST) ? ST_DONE : ST_LOAD;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.clear       = state_q == ST_CLEAR;
    assign bus.busy        = state_q == ST_LOAD;
    assign bus.done        = state_q == ST_DONE;
    assign bus.channel_idx = idx_q;
    assign bus.load_count  = cnt_q;

    onehot_decoder #(.CHANNELS(CHANNELS)) u_dec (
        .idx    (idx_q),
        .en     (state_q == ST_LOAD && !bus.pause),
        .onehot (bus.load)
    );

endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed scoreboard bench for the load sequencer at three sizes
module tb_load_sequencer;

    typedef struct {
        int         d;
        logic [11:0] v;
    } exp_t;

    localparam logic [11:0] CLR = 12'b1_0000_00_000_0_0;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";

    always #5 clock = ~clock;

    load_sequencer_if #(.CHANNELS(4), .LOADS_PER_CH(8)) if0 ();
    load_sequencer_if #(.CHANNELS(1), .LOADS_PER_CH(1)) if1 ();
    load_sequencer_if #(.CHANNELS(3), .LOADS_PER_CH(2)) if2 ();

    load_sequencer #(.CHANNELS(4), .LOADS_PER_CH(8)) u0 (.clock(clock), .reset(reset), .bus(if0));
    load_sequencer #(.CHANNELS(1), .LOADS_PER_CH(1)) u1 (.clock(clock), .reset(reset), .bus(if1));
    load_sequencer #(.CHANNELS(3), .LOADS_PER_CH(2)) u2 (.clock(clock), .reset(reset), .bus(if2));

    // packed view: {clear, load[3:0], idx[1:0], count[2:0], busy, done}
    function automatic logic [11:0] ex(logic clr, logic [3:0] ld, int idx, int cnt, logic bsy, logic dn);
        return {clr, ld, idx[1:0], cnt[2:0], bsy, dn};
    endfunction

    function automatic logic [11:0] ld4(int k);
        return ex(1'b0, 4'(1 << (k % 4)), k % 4, k / 4, 1'b1, 1'b0);
    endfunction

    function automatic logic [11:0] obs(int d);
        case (d)
            0:       return {if0.clear, if0.load, if0.channel_idx, if0.load_count, if0.busy, if0.done};
            1:       return {if1.clear, 3'b0, if1.load, 1'b0, if1.channel_idx, 2'b0, if1.load_count, if1.busy, if1.done};
            default: return {if2.clear, 1'b0, if2.load, if2.channel_idx, 2'b0, if2.load_count, if2.busy, if2.done};
        endcase
    endfunction

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (obs(e.d) === e.v)
        else begin
            n_err++;
            $error("FAIL %s dut%0d cmp%0d: observed %b expected %b", phase, e.d, n_cmp, obs(e.d), e.v);
        end
    endtask

    task automatic chk(int d, logic [11:0] v);
        sb.push_back('{d, v});
        check();
    endtask

    // drive one instance's controls, check its outputs mid-cycle, then take the edge
    task automatic cyc(int d, logic s, logic p, logic a, logic [11:0] v);
        {if0.start, if0.pause, if0.abort} = (d == 0) ? {s, p, a} : 3'b0;
        {if1.start, if1.pause, if1.abort} = (d == 1) ? {s, p, a} : 3'b0;
        {if2.start, if2.pause, if2.abort} = (d == 2) ? {s, p, a} : 3'b0;
        sb.push_back('{d, v});
        #2;
        check();
        @(posedge clock);
        #1;
    endtask

    initial begin
        {if0.start, if0.pause, if0.abort} = 3'b100;
        {if1.start, if1.pause, if1.abort} = 3'b100;
        {if2.start, if2.pause, if2.abort} = 3'b100;
        @(posedge clock);
        #1;
        phase = "reset";
        chk(1, CLR);
        chk(2, CLR);
        cyc(0, 1, 0, 0, CLR);
        cyc(0, 1, 0, 0, CLR);
        reset = 1'b1;

        phase = "full";
        cyc(0, 1, 0, 0, CLR);
        for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0, ld4(k));
        cyc(0, 0, 0, 0, ex(0, 4'b0, 0, 7, 0, 1));
        cyc(0, 0, 0, 0, CLR);

        phase = "pause";
        cyc(0, 1, 0, 0, CLR);
        for (int k = 0; k < 22; k++) cyc(0, 0, 0, 0, ld4(k));
        repeat (3) cyc(0, 0, 1, 0, ex(0, 4'b0, 2, 5, 1, 0));
        for (int k = 22; k < 32; k++) cyc(0, 0, 0, 0, ld4(k));
        cyc(0, 0, 0, 0, ex(0, 4'b0, 0, 7, 0, 1));
        cyc(0, 0, 0, 0, CLR);

        phase = "abort";
        cyc(0, 1, 0, 0, CLR);
        for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0, ld4(k));
        cyc(0, 0, 1, 1, ex(0, 4'b0, 1, 2, 1, 0));
        cyc(0, 0, 0, 0, CLR);
        cyc(0, 0, 0, 0, CLR);

        phase = "midreset";
        cyc(0, 1, 0, 0, CLR);
        for (int k = 0; k < 31; k++) cyc(0, 0, 0, 0, ld4(k));
        reset = 1'b0;
        cyc(0, 0, 0, 0, ld4(31));
        reset = 1'b1;
        cyc(0, 0, 0, 0, CLR);
        cyc(0, 0, 0, 0, CLR);

        phase = "heldstart";
        cyc(0, 1, 0, 0, CLR);
        for (int k = 0; k < 32; k++) cyc(0, 1, 0, 0, ld4(k));
        cyc(0, 1, 0, 0, ex(0, 4'b0, 0, 7, 0, 1));
        cyc(0, 1, 0, 0, CLR);
        cyc(0, 0, 0, 1, ld4(0));
        cyc(0, 0, 0, 0, CLR);

        phase = "c1l1";
        cyc(1, 1, 0, 0, CLR);
        cyc(1, 0, 0, 0, ex(0, 4'b0001, 0, 0, 1, 0));
        cyc(1, 0, 0, 0, ex(0, 4'b0, 0, 0, 0, 1));
        cyc(1, 0, 0, 0, CLR);

        phase = "c3l2";
        cyc(2, 1, 0, 0, CLR);
        for (int k = 0; k < 6; k++) cyc(2, 0, 0, 0, ex(0, 4'(1 << (k % 3)), k % 3, k / 3, 1, 0));
        cyc(2, 0, 0, 0, ex(0, 4'b0, 0, 1, 0, 1));
        cyc(2, 0, 0, 0, CLR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Parametrised successor to the two-state clear/load controller.
- Drives a bank of CHANNELS datapath registers.
- Issues a clear phase, then round-robin one-hot load strobes, LOADS_PER_CH per channel, with pause and abort control.
- Signals completion with a one-cycle done pulse, then re-arms into the clear phase.

Parameters:
- CHANNELS, 4, number of register channels driven (>=1).
- LOADS_PER_CH, 8, load strobes delivered to each channel per run (>=1).
- CH_W, max(1,$clog2(CHANNELS)), derived width of channel_idx.
- CNT_W, max(1,$clog2(LOADS_PER_CH)), derived width of load_count.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clock.
- start  input  1  begin a run; honoured only in state CLEAR.
- pause  input  1  stall the load sequence while high.
- abort  input  1  terminate the run; return to CLEAR without done.
- clear  output 1  register-bank clear strobe.
- load  output CHANNELS  one-hot load strobe, bit i loads channel i.
- channel_idx  output CH_W  channel targeted by the current/next strobe.
- load_count  output CNT_W  completed passes over all channels.
- busy  output 1  high while in LOAD.
- done  output 1  one-cycle completion pulse.

Behaviour:
- Clock and reset are fixed: one clock, `clock`; reset is synchronous and active-low, `reset`.
- reset==0 at posedge forces state CLEAR, channel_idx=0, load_count=0. reset has priority over every other input.
- Outputs after reset: clear=1, load=0, busy=0, done=0.
- States are CLEAR, LOAD and DONE. Outputs are decoded from the registered state; the only combinational input path is pause gating load.
- CLEAR:
  - Outputs: clear=1, load=0, busy=0, done=0.
  - start==1 at posedge -> LOAD, with idx=0 and count=0. Otherwise stay in CLEAR.
- LOAD:
  - Outputs: clear=0, busy=1. load = onehot(channel_idx) when pause==0, else all zeros.
  - abort==1 at posedge -> CLEAR; idx and count reset. abort beats pause and beats completion.
  - pause==1 (no abort): state, idx and count all hold. No strobe is issued that cycle.
  - Otherwise: idx increments. At idx==CHANNELS-1, idx wraps to 0 and count increments.
  - When idx==CHANNELS-1 and count==LOADS_PER_CH-1 -> DONE. count is not incremented past LOADS_PER_CH-1.
- DONE:
  - Outputs: done=1, clear=0, load=0, busy=0.
  - Unconditionally -> CLEAR next cycle. start, pause and abort are ignored.
- start is ignored in LOAD and DONE. No queuing: a start held high through DONE relaunches only once CLEAR has been observed for one cycle.
- Latency: start sampled -> first strobe on the next cycle. An unpaused run gives exactly CHANNELS*LOADS_PER_CH strobe cycles, then 1 DONE cycle.
- Every strobe cycle has exactly one load bit set. load and clear are never high together.
- CHANNELS==1: idx is constantly 0 and count advances every strobe.
- LOADS_PER_CH==1: a single pass over the channels, then DONE.
- Illegal 2-bit state encoding -> CLEAR.

Decomposition:
- Shared package (include file) holds:
  - state encodings: CLEAR=2'b00, LOAD=2'b01, DONE=2'b10;
  - the clog2 width helper.
- One natural sub-module, `onehot_decoder`, parametrised by CHANNELS: converts channel_idx plus an enable into the load vector.
- Next-state logic, counters and output decode live in load_sequencer itself.

Test Plan (CHANNELS=4, LOADS_PER_CH=8 unless stated):
- Reset: hold reset=0 for 2 cycles with start=1 -> clear=1, load=0, busy=0, done=0, idx=0, count=0; no transition to LOAD.
- Full run: start pulse at edge T -> load=0001,0010,0100,1000 repeating for cycles T+1..T+32; count reaches 7; done=1 only at T+33; clear=1 at T+34.
- Pause: pause=1 for 3 cycles while idx=2, count=5 -> load=0000 and idx/count frozen for those 3 cycles; then 0100 resumes; done is delayed by exactly 3 cycles.
- Abort: abort=1 at strobe 10 with pause=1 simultaneously -> next cycle clear=1, idx=0, count=0; done never pulses.
- Mid-run reset: reset=0 during LOAD at idx=3, count=7 (final strobe) -> CLEAR next cycle with no done pulse; start held high through DONE in a separate run -> exactly one relaunch after a CLEAR cycle.
- Degenerate sizes: CHANNELS=1, LOADS_PER_CH=1 -> one strobe load=1, then done, then clear; CHANNELS=3 -> idx wraps from 2 to 0.
